amba_axi4_stream_rr_arbiter: RTL and testbench
==============================================

# amba_axi4_stream_rr_arbiter

Packet-level round-robin arbiter that shares one AXI4-Stream sink between N_SRC AXI4-Stream sources. A grant is locked for the whole packet and released only on the TLAST handshake, so the merged stream never interleaves beats of different packets. It sits in front of any single-sink stream consumer and is meant to be bound, on both sides, with the team's AXI4-Stream source/sink checkers for formal proof.

## Interface
- N_SRC, 4: number of sources, 2..16.
- DATA_BYTES, 4: TDATA width in bytes; TSTRB/TKEEP are DATA_BYTES wide.
- ID_WIDTH, 4: TID width.
- DEST_WIDTH, 4: TDEST width.
- USER_WIDTH, 1: TUSER width.
- GW: derived, $clog2(N_SRC); not overridable.

- ACLK  in  1  clock; all logic on the rising edge.
- ARESETn  in  1  reset; asynchronous assert, synchronous deassert, active-low.
- S_TVALID  in  N_SRC  per-source valid.
- S_TREADY  out  N_SRC  per-source ready.
- S_TDATA  in  N_SRC*DATA_BYTES*8  packed; source i at slice i.
- S_TSTRB, S_TKEEP  in  N_SRC*DATA_BYTES  packed.
- S_TLAST  in  N_SRC  packed.
- S_TID  in  N_SRC*ID_WIDTH  packed.
- S_TDEST  in  N_SRC*DEST_WIDTH  packed.
- S_TUSER  in  N_SRC*USER_WIDTH  packed.
- M_TVALID, M_TREADY  out/in  1  merged stream handshake.
- M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER  out  single-source widths  merged payload.
- GRANT  out  GW  index of the locked source; valid only while BUSY.
- BUSY  out  1  a packet is locked.

## Operation
- States: IDLE, LOCKED. Registered grant index g and round-robin pointer last.
- IDLE: M_TVALID=0, all S_TREADY=0. If any S_TVALID is set, pick the first set bit searching last+1, last+2, ... mod N_SRC. Register g, go to LOCKED.
- LOCKED: M_* payload and M_TVALID = source g signals. S_TREADY[g]=M_TREADY. All other S_TREADY=0. No combinational path from S_TVALID of non-granted sources to any output.
- Beat transfer: M_TVALID & M_TREADY.
- On a transfer with M_TLAST=1: set last=g. If any S_TVALID other than g is set, or g itself is set, re-arbitrate in the same cycle from g+1, with g eligible last. Stay LOCKED with the new g next cycle. Otherwise go to IDLE. BUSY drops.
- Transfers without TLAST never change g. Starvation bound: a waiting source is granted after at most N_SRC-1 packets.
- Payload is passed through unmodified; TID/TDEST are not rewritten.
- AXI4-Stream stability on M_* (no TVALID drop or payload change before handshake) follows from g being frozen mid-packet and from source compliance. The arbiter must not add violations.

## Timing
- Reset (asynchronous): state IDLE, last=N_SRC-1 (first search starts at 0), g=0. M_TVALID=0, S_TREADY=0, BUSY=0, GRANT=0. M_* payload is don't-care but driven from source 0.
- Arbitration latency from IDLE: request seen in cycle t, first beat may transfer in cycle t+1.
- Back-to-back packets: zero bubble. The last beat of packet A in cycle k allows the first beat of packet B (another source) in cycle k+1.
- Datapath latency while LOCKED: 0 cycles (combinational), ready path combinational M_TREADY -> S_TREADY[g].
- Single-beat packets (TLAST on first beat) are legal; each costs one cycle.
- ARESETn asserted mid-packet: the grant is dropped immediately, the packet is truncated, and after release the arbitration restarts from source 0.
- Simultaneous requests at reset release: source 0 wins.

## Test plan
- Sources 0,2 request together after reset, 3-beat packets each, M_TREADY=1 -> source 0 beats in cycles 1-3, then source 2 in cycles 4-6. No gap. GRANT 0 then 2. BUSY high cycles 1-6.
- All 4 sources continuously request 1-beat packets -> grant order 0,1,2,3,0,1,... with one beat per cycle.
- Source 1 mid-packet while source 0 asserts valid; M_TREADY toggles 1,0,0,1 -> S_TREADY[0]=0 throughout, M_* stable during stalls, source 1 completes before any source 0 beat.
- Source 3 sends 2 packets while no one else requests -> re-grant to 3 with no bubble. IDLE is entered only after the second TLAST with no valid present.
- ARESETn pulsed low during beat 2 of a 4-beat source-2 packet -> M_TVALID=0 and BUSY=0 in the same cycle. After release with sources 1 and 2 requesting, source 1 wins.
- Formal: bind the AXI4-Stream source checkers on every S_* and a sink checker on M_* -> all assertions proven. Cover reaches a grant to every source.

Source files
------------

// File: rtl/amba_axi4_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// amba_axi4_stream_rr_arbiter : packet-locked round-robin merge of N_SRC
// AXI4-Stream sources onto one sink.            Revision 1.0
// ============================================================================
module amba_axi4_stream_rr_arbiter #(
  parameter  int N_SRC      = 4,
  parameter  int DATA_BYTES = 4,
  parameter  int ID_WIDTH   = 4,
  parameter  int DEST_WIDTH = 4,
  parameter  int USER_WIDTH = 1,
  localparam int GW         = $clog2(N_SRC)
) (
  input  logic                             ACLK,
  input  logic                             ARESETn,
  input  logic [N_SRC-1:0]                 S_TVALID,
  output logic [N_SRC-1:0]                 S_TREADY,
  input  logic [N_SRC*DATA_BYTES*8-1:0]    S_TDATA,
  input  logic [N_SRC*DATA_BYTES-1:0]      S_TSTRB,
  input  logic [N_SRC*DATA_BYTES-1:0]      S_TKEEP,
  input  logic [N_SRC-1:0]                 S_TLAST,
  input  logic [N_SRC*ID_WIDTH-1:0]        S_TID,
  input  logic [N_SRC*DEST_WIDTH-1:0]      S_TDEST,
  input  logic [N_SRC*USER_WIDTH-1:0]      S_TUSER,
  output logic                             M_TVALID,
  input  logic                             M_TREADY,
  output logic [DATA_BYTES*8-1:0]          M_TDATA,
  output logic [DATA_BYTES-1:0]            M_TSTRB,
  output logic [DATA_BYTES-1:0]            M_TKEEP,
  output logic                             M_TLAST,
  output logic [ID_WIDTH-1:0]              M_TID,
  output logic [DEST_WIDTH-1:0]            M_TDEST,
  output logic [USER_WIDTH-1:0]            M_TUSER,
  output logic [GW-1:0]                    GRANT,
  output logic                             BUSY
);

  localparam int DW = DATA_BYTES * 8;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic            started_q, started_d;

  logic [GW-1:0]   pick_base;
  logic [GW-1:0]   pick_idx;
  logic            pick_found;
  logic            xfer;
  int              j;

  // Search starts one past the base and wraps, so the base itself is checked last.
  assign pick_base = (state_q == ST_IDLE) ? last_q : grant_q;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    j          = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      j = int'(pick_base) + k;
      if (j >= N_SRC) j = j - N_SRC;
      if (!pick_found && S_TVALID[j]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(j);
      end
    end
  end

  assign xfer = (state_q == ST_LOCKED) && S_TVALID[grant_q] && M_TREADY;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    started_d = started_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d   = ST_LOCKED;
          grant_d   = pick_idx;
          started_d = 1'b0;
        end
      end
      ST_LOCKED: begin
        if (xfer && S_TLAST[grant_q]) begin
          last_d    = grant_q;
          started_d = 1'b0;
          if (pick_found) grant_d = pick_idx;
          else            state_d = ST_IDLE;
        end else if (xfer) begin
          started_d = 1'b1;
        end else if (!started_q && !S_TVALID[grant_q]) begin
          // A re-grant to a source whose next packet never showed up is released here.
          if (pick_found) grant_d = pick_idx;
          else            state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      last_q    <= GW'(N_SRC - 1);
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      started_q <= started_d;
    end
  end

  assign BUSY     = (state_q == ST_LOCKED);
  assign GRANT    = grant_q;
  assign M_TVALID = BUSY && S_TVALID[grant_q];

  always_comb begin
    S_TREADY = '0;
    if (BUSY) S_TREADY[grant_q] = M_TREADY;
  end

  assign M_TDATA = S_TDATA[grant_q*DW +: DW];
  assign M_TSTRB = S_TSTRB[grant_q*DATA_BYTES +: DATA_BYTES];
  assign M_TKEEP = S_TKEEP[grant_q*DATA_BYTES +: DATA_BYTES];
  assign M_TLAST = S_TLAST[grant_q];
  assign M_TID   = S_TID[grant_q*ID_WIDTH +: ID_WIDTH];
  assign M_TDEST = S_TDEST[grant_q*DEST_WIDTH +: DEST_WIDTH];
  assign M_TUSER = S_TUSER[grant_q*USER_WIDTH +: USER_WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_amba_axi4_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_amba_axi4_stream_rr_arbiter : directed and randomized check of the
// packet round-robin arbiter against a packet-level model.   Revision 1.0
// ============================================================================
module tb_amba_axi4_stream_rr_arbiter;

  localparam int N   = 4;
  localparam int DB  = 4;
  localparam int DW  = 32;
  localparam int IW  = 4;
  localparam int DSW = 4;
  localparam int UW  = 1;
  localparam int GW  = 2;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic [N-1:0]      S_TVALID, S_TREADY, S_TLAST;
  logic [N*DW-1:0]   S_TDATA;
  logic [N*DB-1:0]   S_TSTRB, S_TKEEP;
  logic [N*IW-1:0]   S_TID;
  logic [N*DSW-1:0]  S_TDEST;
  logic [N*UW-1:0]   S_TUSER;
  logic              M_TVALID, M_TREADY, M_TLAST;
  logic [DW-1:0]     M_TDATA;
  logic [DB-1:0]     M_TSTRB, M_TKEEP;
  logic [IW-1:0]     M_TID;
  logic [DSW-1:0]    M_TDEST;
  logic [UW-1:0]     M_TUSER;
  logic [GW-1:0]     GRANT;
  logic              BUSY;

  amba_axi4_stream_rr_arbiter #(
    .N_SRC(N), .DATA_BYTES(DB), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA), .S_TSTRB(S_TSTRB),
    .S_TKEEP(S_TKEEP), .S_TLAST(S_TLAST), .S_TID(S_TID), .S_TDEST(S_TDEST), .S_TUSER(S_TUSER),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA), .M_TSTRB(M_TSTRB),
    .M_TKEEP(M_TKEEP), .M_TLAST(M_TLAST), .M_TID(M_TID), .M_TDEST(M_TDEST), .M_TUSER(M_TUSER),
    .GRANT(GRANT), .BUSY(BUSY)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source model: each source owns a count of packets still to send.
  int           left [N];
  int           len  [N];
  int           beat [N];
  int           pkt  [N];
  logic [N-1:0] vld;
  int           fix_len;
  int           p_mid, p_start;
  int           ready_mode;
  logic         tr_tab [16];

  function automatic logic [31:0] beat_data(input int s, input int p, input int b);
    return {8'(s), 8'(p), 8'(b), 8'(8'hA5 ^ 8'(s))};
  endfunction

  function automatic int new_len();
    return (fix_len > 0) ? fix_len : int'($urandom_range(1, 4));
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int base);
    for (int k = 1; k <= N; k++) begin
      if (v[(base + k) % N]) return (base + k) % N;
    end
    return base;
  endfunction

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      S_TVALID[i]            = vld[i];
      S_TDATA[i*DW +: DW]    = beat_data(i, pkt[i], beat[i]);
      S_TLAST[i]             = (beat[i] == len[i] - 1);
      S_TID[i*IW +: IW]      = IW'(i);
      S_TDEST[i*DSW +: DSW]  = DSW'(pkt[i]);
      S_TUSER[i]             = beat[i][0];
      S_TKEEP[i*DB +: DB]    = '1;
      S_TSTRB[i*DB +: DB]    = DB'(beat[i] + 1);
    end
  endtask

  task automatic src_setup(input int i, input int npk, input int l, input logic start_v);
    fix_len = l;
    left[i] = npk;
    len[i]  = new_len();
    beat[i] = 0;
    pkt[i]  = 0;
    vld[i]  = start_v && (npk > 0);
  endtask

  task automatic drive_update(input logic [N-1:0] hs);
    logic fin;
    for (int i = 0; i < N; i++) begin
      fin = 1'b0;
      if (hs[i]) begin
        beat[i]++;
        if (beat[i] >= len[i]) begin
          beat[i] = 0;
          pkt[i]++;
          left[i]--;
          len[i]  = new_len();
          fin     = 1'b1;
        end
      end
      if (vld[i] && !hs[i])  vld[i] = 1'b1;
      else if (left[i] == 0) vld[i] = 1'b0;
      else if (beat[i] != 0) vld[i] = ($urandom_range(0, 99) < p_mid);
      else if (fin)          vld[i] = 1'b1;
      else                   vld[i] = ($urandom_range(0, 99) < p_start);
    end
    drive_bus();
  endtask

  // Packet-level observer of the merged stream.
  int           cyc;
  int           log_src [64];
  logic         log_busy [64];
  logic [GW-1:0] log_grant [64];
  logic [N-1:0] log_srdy [64];
  logic [N-1:0] hs_s;
  logic         in_pkt, exp_valid, prev_stall;
  int           cur_src, exp_owner;
  logic [DW+IW:0] prev_payload;

  task automatic obs_reset();
    cyc = 0; in_pkt = 0; exp_valid = 0; prev_stall = 0; cur_src = 0; exp_owner = 0;
    for (int c = 0; c < 64; c++) log_src[c] = -1;
  endtask

  task automatic sample();
    int s;
    logic [N-1:0] er;
    hs_s = S_TVALID & S_TREADY;
    if (cyc < 64) begin
      log_src[cyc]   = (M_TVALID && M_TREADY) ? int'(M_TID) : -1;
      log_busy[cyc]  = BUSY;
      log_grant[cyc] = GRANT;
      log_srdy[cyc]  = S_TREADY;
    end
    if (prev_stall) begin
      check("stall_valid", 64'(M_TVALID), 64'd1);
      check("stall_payload", 64'({M_TDATA, M_TID, M_TLAST}), 64'(prev_payload));
    end
    if (M_TVALID) begin
      s = int'(M_TID);
      if (s >= N) begin
        check("beat_src_range", 64'(s), 64'(N - 1));
      end else begin
        er = '0;
        er[s] = M_TREADY;
        check("ready_route", 64'(S_TREADY), 64'(er));
        check("src_valid", 64'(S_TVALID[s]), 64'd1);
        if (M_TREADY) begin
          check("beat_data", 64'(M_TDATA), 64'(beat_data(s, pkt[s], beat[s])));
          check("beat_last", 64'(M_TLAST), 64'(beat[s] == len[s] - 1));
          if (in_pkt)         check("no_interleave", 64'(s), 64'(cur_src));
          else if (exp_valid) check("rr_order", 64'(s), 64'(exp_owner));
          if (M_TLAST) begin
            in_pkt    = 0;
            exp_owner = rr_pick(S_TVALID, s);
            exp_valid = (exp_owner != s) || (left[s] > 1);
          end else begin
            in_pkt  = 1;
            cur_src = s;
          end
        end
      end
    end else begin
      check("no_stray_hs", 64'(S_TVALID & S_TREADY), 64'd0);
    end
    prev_stall   = M_TVALID && !M_TREADY;
    prev_payload = {M_TDATA, M_TID, M_TLAST};
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge ACLK);
      sample();
      @(posedge ACLK);
      #1;
      drive_update(hs_s);
      if (ready_mode == 1)                 M_TREADY = ($urandom_range(0, 99) < 70);
      else if (ready_mode == 2 && cyc < 16) M_TREADY = tr_tab[cyc];
    end
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) src_setup(i, 0, 1, 1'b0);
  endtask

  task automatic restart();
    @(posedge ACLK);
    #1;
    ARESETn = 1'b0;
    drive_bus();
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    obs_reset();
  endtask

  function automatic int sum_left();
    int t = 0;
    for (int i = 0; i < N; i++) t += left[i];
    return t;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    M_TREADY = 1'b1; ready_mode = 0; p_mid = 100; p_start = 100;
    clear_srcs();
    // Directed 1: sources 0 and 2, one 3-beat packet each.
    src_setup(0, 1, 3, 1'b1);
    src_setup(2, 1, 3, 1'b1);
    drive_bus();
    @(negedge ACLK);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_mvalid", 64'(M_TVALID), 64'd0);
    check("rst_sready", 64'(S_TREADY), 64'd0);
    check("rst_grant", 64'(GRANT), 64'd0);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    obs_reset();
    run(10);
    for (int c = 0; c <= 7; c++)
      check($sformatf("t1_src_c%0d", c), 64'(log_src[c]),
            64'((c >= 1 && c <= 3) ? 0 : (c >= 4 && c <= 6) ? 2 : -1));
    for (int c = 0; c <= 6; c++) check($sformatf("t1_busy_c%0d", c), 64'(log_busy[c]), 64'(c >= 1));
    for (int c = 1; c <= 6; c++) check($sformatf("t1_grant_c%0d", c), 64'(log_grant[c]), 64'(c <= 3 ? 0 : 2));
    check("t1_idle_end", 64'(log_busy[8]), 64'd0);

    // Directed 2: all four sources stream single-beat packets.
    clear_srcs();
    for (int i = 0; i < N; i++) src_setup(i, 3, 1, 1'b1);
    restart();
    run(15);
    for (int c = 0; c <= 13; c++)
      check($sformatf("t2_src_c%0d", c), 64'(log_src[c]), 64'((c >= 1 && c <= 12) ? (c - 1) % 4 : -1));

    // Directed 3: source 1 mid-packet, source 0 waiting, sink stalls.
    clear_srcs();
    src_setup(1, 1, 3, 1'b1);
    src_setup(0, 1, 1, 1'b0);
    p_start = 0;
    for (int c = 0; c < 16; c++) tr_tab[c] = !(c == 2 || c == 3);
    M_TREADY = tr_tab[0];
    ready_mode = 2;
    restart();
    run(2);
    vld[0] = 1'b1;
    drive_bus();
    run(8);
    for (int c = 1; c <= 6; c++)
      check($sformatf("t3_src_c%0d", c), 64'(log_src[c]), 64'((c == 2 || c == 3) ? -1 : (c == 6) ? 0 : 1));
    for (int c = 2; c <= 5; c++) check($sformatf("t3_rdy0_c%0d", c), 64'(log_srdy[c][0]), 64'd0);
    ready_mode = 0; M_TREADY = 1'b1; p_start = 100;

    // Directed 4: source 3 alone sends two 2-beat packets back to back.
    clear_srcs();
    src_setup(3, 2, 2, 1'b1);
    restart();
    run(8);
    for (int c = 0; c <= 5; c++)
      check($sformatf("t4_src_c%0d", c), 64'(log_src[c]), 64'((c >= 1 && c <= 4) ? 3 : -1));
    check("t4_idle", 64'(log_busy[6]), 64'd0);

    // Directed 5: reset pulsed during beat 2 of a 4-beat packet from source 2.
    clear_srcs();
    src_setup(2, 1, 4, 1'b1);
    restart();
    run(2);
    #1;
    ARESETn = 1'b0;
    #1;
    check("t5_mvalid_rst", 64'(M_TVALID), 64'd0);
    check("t5_busy_rst", 64'(BUSY), 64'd0);
    check("t5_grant_rst", 64'(GRANT), 64'd0);
    clear_srcs();
    src_setup(1, 1, 1, 1'b1);
    src_setup(2, 1, 2, 1'b1);
    drive_bus();
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    obs_reset();
    run(6);
    for (int c = 0; c <= 3; c++)
      check($sformatf("t5_src_c%0d", c), 64'(log_src[c]), 64'(c == 0 ? -1 : c == 1 ? 1 : 2));

    // Randomized traffic with random gaps and random back-pressure.
    clear_srcs();
    p_mid = 70; p_start = 50; ready_mode = 1;
    for (int i = 0; i < N; i++) src_setup(i, int'($urandom_range(6, 10)), 0, 1'($urandom_range(0, 1)));
    restart();
    n = 0;
    while (sum_left() > 0 && n < 4000) begin
      run(1);
      n++;
    end
    check("rand_all_delivered", 64'(sum_left()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
